// File: rtl/float_add_seq.sv
// rtl/float_add_seq.sv - multi-cycle sequenced IEEE-754 single-precision add/subtract unit
module float_add_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 zero,
  output logic                 ovf
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 2;   // carry + hidden + fraction
  localparam int XW = EXP_W + 1;   // spare top bit so exponent steps never wrap
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [XW-1:0]    EXP_INF   = {1'b0, EXP_ONES};
  localparam logic [XW-1:0]    SHIFT_LIM = XW'(MW);
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
  state_t state, state_nx;

  logic          sa_r, sb_r, sx_r, sub_r;
  logic [XW-1:0] ea_r, eb_r, ex_r;
  logic [MW-1:0] ma_r, mb_r, mx_r, my_r, m_r;
  logic [W-1:0]  result_r;
  logic          zero_r, ovf_r;

  // Operand decode straight off the ports; exp==0 flushes to a zero magnitude
  logic [EXP_W-1:0] a_exp, b_exp;
  logic             special;
  assign a_exp   = a[W-2:MAN_W];
  assign b_exp   = b[W-2:MAN_W];
  assign special = (a_exp == EXP_ONES) || (b_exp == EXP_ONES);

  // Magnitude ordering and alignment of the smaller operand (A wins ties)
  logic          a_larger;
  logic [XW-1:0] ex_sel, ey_sel, shift_amt;
  logic [MW-1:0] mx_sel, my_sel, my_aligned;
  assign a_larger   = {ea_r, ma_r} >= {eb_r, mb_r};
  assign ex_sel     = a_larger ? ea_r : eb_r;
  assign ey_sel     = a_larger ? eb_r : ea_r;
  assign mx_sel     = a_larger ? ma_r : mb_r;
  assign my_sel     = a_larger ? mb_r : ma_r;
  assign shift_amt  = ex_sel - ey_sel;
  assign my_aligned = (shift_amt >= SHIFT_LIM) ? '0 : (my_sel >> shift_amt);

  // Normalisation step conditions
  logic          m_is_zero, m_carry, m_normal, exp_at_inf, exp_at_zero;
  logic [XW-1:0] exp_inc, exp_dec;
  assign exp_inc     = ex_r + XW'(1);
  assign exp_dec     = ex_r - XW'(1);
  assign m_is_zero   = (m_r == '0);
  assign m_carry     = m_r[MW-1];
  assign m_normal    = m_r[MW-2];
  assign exp_at_inf  = (exp_inc == EXP_INF);
  assign exp_at_zero = (exp_dec == '0);

  assign result = result_r;
  assign zero   = zero_r;
  assign ovf    = ovf_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and status outputs
  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    case (state)
      S_IDLE:  if (start) state_nx = special ? S_DONE : S_ALIGN;
      S_ALIGN: state_nx = S_ADD;
      S_ADD:   state_nx = S_NORM;
      S_NORM: begin
        if (m_is_zero)     state_nx = S_DONE;
        else if (m_carry)  state_nx = exp_at_inf ? S_DONE : S_NORM;
        else if (m_normal) state_nx = S_DONE;
        else               state_nx = exp_at_zero ? S_DONE : S_NORM;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: latch, align, add, normalise; result/zero/ovf load on entry to DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa_r <= 1'b0; sb_r <= 1'b0; sx_r <= 1'b0; sub_r <= 1'b0;
      ea_r <= '0; eb_r <= '0; ex_r <= '0;
      ma_r <= '0; mb_r <= '0; mx_r <= '0; my_r <= '0; m_r <= '0;
      result_r <= '0; zero_r <= 1'b0; ovf_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sa_r <= a[W-1];
          sb_r <= b[W-1] ^ op;
          ea_r <= {1'b0, a_exp};
          eb_r <= {1'b0, b_exp};
          ma_r <= (a_exp == '0) ? '0 : {2'b01, a[MAN_W-1:0]};
          mb_r <= (b_exp == '0) ? '0 : {2'b01, b[MAN_W-1:0]};
          if (special) begin
            result_r <= QNAN; zero_r <= 1'b0; ovf_r <= 1'b0;
          end
        end
        S_ALIGN: begin
          sx_r  <= a_larger ? sa_r : sb_r;
          sub_r <= sa_r ^ sb_r;
          ex_r  <= ex_sel;
          mx_r  <= mx_sel;
          my_r  <= my_aligned;
        end
        S_ADD: m_r <= sub_r ? (mx_r - my_r) : (mx_r + my_r);
        S_NORM: begin
          if (m_is_zero) begin
            result_r <= '0; zero_r <= 1'b1; ovf_r <= 1'b0;
          end else if (m_carry) begin
            m_r  <= m_r >> 1;
            ex_r <= exp_inc;
            if (exp_at_inf) begin
              result_r <= {sx_r, EXP_ONES, {MAN_W{1'b0}}}; zero_r <= 1'b0; ovf_r <= 1'b1;
            end
          end else if (m_normal) begin
            result_r <= {sx_r, ex_r[EXP_W-1:0], m_r[MAN_W-1:0]}; zero_r <= 1'b0; ovf_r <= 1'b0;
          end else begin
            m_r  <= m_r << 1;
            ex_r <= exp_dec;
            if (exp_at_zero) begin
              result_r <= '0; zero_r <= 1'b1; ovf_r <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
